// File: rtl/maxpool_2x2_core.sv
// maxpool_2x2_core: streaming 2x2 stride-2 signed max-pool feeding a ready-gated output FIFO
module maxpool_2x2_core #(
  parameter int LANES    = 16,
  parameter int COL_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [COL_BITS-1:0] col_num,
  input  logic [COL_BITS-1:0] row_num,
  input  logic                s_valid,
  input  logic [LANES*8-1:0]  s_data,
  output logic                s_ready,
  input  logic                fifo_ready,
  output logic                fifo_wr_en,
  output logic [LANES*8-1:0]  fifo_din,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);
  localparam int W     = LANES * 8;
  localparam int DEPTH = 2 ** (COL_BITS - 1);
  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, DONE} state_t;
  state_t                state, state_nx;
  logic [COL_BITS-1:0]   col_n, row_n, col_cnt, row_cnt;
  logic [COL_BITS-2:0]   addr;
  logic [W-1:0]          first_reg, rd_data, hmax, vmax;
  logic [W-1:0]          rowbuf [DEPTH];
  logic                  acc, row_end, cfg_ok, go;

  function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++)
      m[i*8 +: 8] = $signed(a[i*8 +: 8]) > $signed(b[i*8 +: 8]) ? a[i*8 +: 8] : b[i*8 +: 8];
    return m;
  endfunction

  assign cfg_ok  = col_num != '0 && row_num != '0 && !col_num[0] && !row_num[0];
  assign go      = state == IDLE && start && cfg_ok;
  assign s_ready = state == EVEN_ROW || (state == ODD_ROW && fifo_ready);
  assign acc     = s_valid && s_ready;
  assign row_end = acc && col_cnt == col_n - 1'b1;
  assign addr    = col_cnt[COL_BITS-1:1];
  assign hmax    = lane_max(first_reg, s_data);
  assign vmax    = lane_max(rd_data, hmax);
  assign busy    = state != IDLE;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  // next state: rows alternate even/odd, last odd row ends the map
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = go ? EVEN_ROW : IDLE;
      EVEN_ROW: state_nx = row_end ? ODD_ROW : EVEN_ROW;
      ODD_ROW:  state_nx = !row_end ? ODD_ROW : (row_cnt == row_n - 1'b1 ? DONE : EVEN_ROW);
      default:  state_nx = IDLE;
    endcase
  end

  // counters, pairing register, held row-buffer read data and pooled output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_n      <= '0;
      row_n      <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      first_reg  <= '0;
      rd_data    <= '0;
      fifo_din   <= '0;
      fifo_wr_en <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      done       <= state == DONE;
      cfg_err    <= state == IDLE && start && !cfg_ok;
      if (go) begin
        col_n   <= col_num;
        row_n   <= row_num;
        col_cnt <= '0;
        row_cnt <= '0;
      end
      if (acc) begin
        col_cnt <= row_end ? '0 : col_cnt + 1'b1;
        if (row_end) row_cnt <= row_cnt + 1'b1;
        if (!col_cnt[0]) first_reg <= s_data;
        if (state == ODD_ROW && !col_cnt[0]) rd_data <= rowbuf[addr];
        if (state == ODD_ROW && col_cnt[0]) begin
          fifo_wr_en <= 1'b1;
          fifo_din   <= vmax;
        end
      end
    end

  // even rows park their horizontal maxima for the following odd row
  always_ff @(posedge clk)
    if (acc && state == EVEN_ROW && col_cnt[0]) rowbuf[addr] <= hmax;
endmodule

// File: tb/tb_maxpool_2x2_core.sv
// tb_maxpool_2x2_core: directed self-checking bench for maxpool_2x2_core
module tb_maxpool_2x2_core;
  localparam int LANES = 16;
  localparam int CB    = 10;
  localparam int W     = LANES * 8;

  logic          clk = 0, rst_n = 0, start = 0, s_valid = 0, fifo_ready = 1;
  logic [CB-1:0] col_num = '0, row_num = '0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, fifo_wr_en, busy, done, cfg_err;
  logic [W-1:0]  fifo_din;

  logic [W-1:0]  img [64];
  logic [W-1:0]  wq[$], ref_q[$];
  int            checks = 0, errors = 0, low_wr = 0, max_low = 0;

  maxpool_2x2_core #(.LANES(LANES), .COL_BITS(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .col_num(col_num), .row_num(row_num),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .fifo_ready(fifo_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_wr_en) wq.push_back(fifo_din);

  always @(negedge clk) begin
    if (!fifo_ready) begin
      if (fifo_wr_en) low_wr++;
    end else low_wr = 0;
    if (low_wr > max_low) max_low = low_wr;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] gold(input int cols, input int k);
    logic [W-1:0] g;
    int b;
    g = '0;
    b = (k / (cols / 2)) * 2 * cols + (k % (cols / 2)) * 2;
    for (int l = 0; l < LANES; l++) begin
      logic signed [7:0] m;
      m = img[b][l*8 +: 8];
      for (int j = 1; j < 4; j++) begin
        logic signed [7:0] v;
        v = img[b + (j % 2) + (j / 2) * cols][l*8 +: 8];
        if (v > m) m = v;
      end
      g[l*8 +: 8] = m;
    end
    return g;
  endfunction

  task automatic fill_rand(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      img[i] = {$urandom, $urandom, $urandom, $urandom};
      if (ramp) img[i][7:0] = 8'(i);
    end
  endtask

  task automatic do_start(input int c, input int r);
    wq.delete();
    col_num = CB'(c);
    row_num = CB'(r);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send_beats(input int cols, input int first, input int last, input bit bp, input bit gap);
    for (int i = first; i <= last; i++) begin
      int r, c, n, g;
      bit acc;
      r = i / cols;
      c = i % cols;
      n = 0;
      acc = 0;
      g = gap ? ((c % 2 == 1) ? 2 : int'($urandom_range(0, 1))) : 0;
      s_valid = 0;
      repeat (g) begin @(posedge clk); #1; end
      s_valid = 1;
      s_data = img[i];
      while (!acc && n < 64) begin
        fifo_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (r % 2 == 1 && !fifo_ready) chk("bp_hold", s_ready, 0);
        acc = s_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!acc) chk("accept_timeout", 0, 1);
    end
    s_valid = 0;
    fifo_ready = 1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("done_seen", done, 1);
    chk("busy_with_done", busy, 0);
  endtask

  task automatic check_map(input int cols, input int rows, input string tag);
    int n;
    n = (cols / 2) * (rows / 2);
    chk({tag, "_count"}, wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++) chk({tag, "_data"}, wq[k], gold(cols, k));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_din", fifo_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst_n = 1;
    @(posedge clk); #1;

    fill_rand(16, 1);
    do_start(4, 4);
    send_beats(4, 0, 15, 0, 0);
    chk("basic_last_wr", fifo_wr_en, 1);
    chk("basic_done_early", done, 0);
    @(posedge clk); #1;
    chk("basic_done_t2", done, 1);
    chk("basic_busy_drop", busy, 0);
    @(posedge clk); #1;
    chk("basic_done_pulse", done, 0);
    check_map(4, 4, "basic");
    if (wq.size() == 4) begin
      chk("basic_l0_0", wq[0][7:0], 5);
      chk("basic_l0_1", wq[1][7:0], 7);
      chk("basic_l0_2", wq[2][7:0], 13);
      chk("basic_l0_3", wq[3][7:0], 15);
    end

    img[0] = {16{8'h80}};
    img[1] = {{8{8'h80}}, {8{8'hFF}}};
    img[2] = {{8{8'h80}}, {8{8'hFB}}};
    img[3] = {{8{8'h80}}, {8{8'hFE}}};
    do_start(2, 2);
    send_beats(2, 0, 3, 0, 0);
    wait_done();
    chk("signed_count", wq.size(), 1);
    if (wq.size() == 1) chk("signed_data", wq[0], {{8{8'h80}}, {8{8'hFF}}});

    col_num = 5;
    row_num = 4;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("cfg_err_odd", cfg_err, 1);
    chk("cfg_busy_odd", busy, 0);
    @(posedge clk); #1;
    chk("cfg_err_pulse", cfg_err, 0);
    col_num = 4;
    row_num = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("cfg_err_zero", cfg_err, 1);
    chk("cfg_busy_zero", busy, 0);

    fill_rand(16, 0);
    do_start(4, 4);
    send_beats(4, 0, 2, 0, 0);
    col_num = 2;
    row_num = 2;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_start_no_err", cfg_err, 0);
    chk("busy_start_busy", busy, 1);
    send_beats(4, 3, 15, 0, 0);
    wait_done();
    check_map(4, 4, "busy_start");

    fill_rand(32, 0);
    do_start(8, 4);
    send_beats(8, 0, 31, 0, 0);
    wait_done();
    check_map(8, 4, "plain84");
    ref_q = wq;

    do_start(8, 4);
    send_beats(8, 0, 31, 0, 1);
    wait_done();
    check_map(8, 4, "gap84");
    chk("gap_vs_plain_count", wq.size(), ref_q.size());
    for (int k = 0; k < wq.size() && k < ref_q.size(); k++) chk("gap_vs_plain", wq[k], ref_q[k]);

    max_low = 0;
    do_start(8, 4);
    send_beats(8, 0, 31, 1, 0);
    wait_done();
    check_map(8, 4, "bp84");
    chk("bp_inflight", max_low <= 1, 1);

    fill_rand(16, 0);
    do_start(4, 4);
    send_beats(4, 0, 5, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_wr_en", fifo_wr_en, 0);
    chk("mid_rst_din", fifo_din, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    fill_rand(16, 0);
    do_start(4, 4);
    send_beats(4, 0, 15, 0, 0);
    wait_done();
    check_map(4, 4, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
